// File: rtl/shift_deser.sv
// Serial-in, parallel-out receiver: collects WIDTH bits LSB- or MSB-first and
// offers each completed word on a valid/ready output, flagging dropped words.
module shift_deser #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin_valid,
  input  logic             sin,
  input  logic             dir,
  input  logic             clear,
  output logic [WIDTH-1:0] q_out,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun
);

  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             dir_l_q, dir_l_d;
  logic [WIDTH-1:0] q_out_q, q_out_d;
  logic             q_valid_q, q_valid_d;
  logic             overrun_q, overrun_d;

  logic             eff_dir;
  logic [WIDTH-1:0] sh_shifted;
  logic             complete;

  // The first bit of a word uses the live dir; later bits use the latched copy.
  assign eff_dir    = (state_q == IDLE) ? dir : dir_l_q;
  assign sh_shifted = eff_dir ? {sh_q[WIDTH-2:0], sin} : {sin, sh_q[WIDTH-1:1]};
  assign complete   = sin_valid && !clear && (bit_cnt_q == LAST_CNT);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    dir_l_d   = dir_l_q;
    q_out_d   = q_out_q;
    q_valid_d = q_valid_q;
    overrun_d = overrun_q;

    if (clear) begin
      state_d   = IDLE;
      sh_d      = '0;
      bit_cnt_d = '0;
      overrun_d = 1'b0;
    end else begin
      if (q_valid_q && q_ready) begin
        q_valid_d = 1'b0;
      end

      if (sin_valid) begin
        unique case (state_q)
          IDLE: begin
            dir_l_d   = dir;
            sh_d      = sh_shifted;
            bit_cnt_d = CNT_W'(1);
            state_d   = COLLECT;
          end
          COLLECT: begin
            if (complete) begin
              sh_d      = '0;
              bit_cnt_d = '0;
              state_d   = IDLE;
            end else begin
              sh_d      = sh_shifted;
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
          default: state_d = IDLE;
        endcase
      end

      // A completed word is delivered only if the output slot is free or
      // being emptied on this same edge; otherwise it is dropped.
      if (complete) begin
        if (!q_valid_q || q_ready) begin
          q_out_d   = sh_shifted;
          q_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      dir_l_q   <= 1'b0;
      q_out_q   <= '0;
      q_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      dir_l_q   <= dir_l_d;
      q_out_q   <= q_out_d;
      q_valid_q <= q_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign q_out   = q_out_q;
  assign q_valid = q_valid_q;
  assign busy    = (bit_cnt_q != '0);
  assign bit_cnt = bit_cnt_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_shift_deser.sv
// Directed self-checking bench for shift_deser at WIDTH=4.
module tb_shift_deser;

  localparam int WIDTH = 4;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             sin_valid;
  logic             sin;
  logic             dir;
  logic             clear;
  logic [WIDTH-1:0] q_out;
  logic             q_valid;
  logic             q_ready;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;
  logic             overrun;

  int n_checks = 0;
  int n_errors = 0;

  shift_deser #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .sin_valid(sin_valid),
    .sin      (sin),
    .dir      (dir),
    .clear    (clear),
    .q_out    (q_out),
    .q_valid  (q_valid),
    .q_ready  (q_ready),
    .busy     (busy),
    .bit_cnt  (bit_cnt),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sin_valid = 1'b1;
    sin       = b;
    step();
    sin_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b0; sin_valid = 1'b0; sin = 1'b0; dir = 1'b0; clear = 1'b0; q_ready = 1'b0;
    #1;
    step();
    rst = 1'b1;
    check("rst_q_out",   q_out,   0);
    check("rst_q_valid", q_valid, 0);
    check("rst_busy",    busy,    0);
    check("rst_bit_cnt", bit_cnt, 0);
    check("rst_overrun", overrun, 0);

    // 1: LSB-first 0,1,0,1 -> 1010
    dir = 1'b0;
    send_bit(0); send_bit(1); send_bit(0);
    check("t1_cnt3",  bit_cnt, 3);
    check("t1_busy3", busy,    1);
    send_bit(1);
    check("t1_q_out",   q_out,   4'b1010);
    check("t1_q_valid", q_valid, 1);
    check("t1_busy",    busy,    0);
    check("t1_cnt",     bit_cnt, 0);
    idle(2);
    check("t1_hold_out",   q_out,   4'b1010);
    check("t1_hold_valid", q_valid, 1);
    q_ready = 1'b1; step(); q_ready = 1'b0;
    check("t1_consumed", q_valid, 0);

    // 2: MSB-first 1,0,1,0 with gaps; dir toggled mid-word is ignored
    dir = 1'b1;
    send_bit(1);
    dir = 1'b0;
    check("t2_cnt1", bit_cnt, 1);
    idle(2);
    check("t2_gap1", bit_cnt, 1);
    send_bit(0);
    check("t2_cnt2", bit_cnt, 2);
    idle(3);
    check("t2_gap2", bit_cnt, 2);
    send_bit(1);
    check("t2_cnt3", bit_cnt, 3);
    idle(1);
    send_bit(0);
    check("t2_q_out",   q_out,   4'b1010);
    check("t2_q_valid", q_valid, 1);
    check("t2_cnt",     bit_cnt, 0);
    q_ready = 1'b1; step(); q_ready = 1'b0;
    check("t2_consumed", q_valid, 0);

    // 3: overrun; 0011 delivered, 1100 dropped, then clear
    dir = 1'b0;
    send_bit(1); send_bit(1); send_bit(0); send_bit(0);
    check("t3_first_out", q_out,   4'b0011);
    check("t3_no_ovr",    overrun, 0);
    send_bit(0); send_bit(0); send_bit(1); send_bit(1);
    check("t3_q_out",   q_out,   4'b0011);
    check("t3_q_valid", q_valid, 1);
    check("t3_overrun", overrun, 1);
    check("t3_cnt",     bit_cnt, 0);
    clear = 1'b1; step(); clear = 1'b0;
    check("t3_clr_ovr",   overrun, 0);
    check("t3_clr_out",   q_out,   4'b0011);
    check("t3_clr_valid", q_valid, 1);

    // 4: completion and handshake on the same edge (0101 LSB-first: 1,0,1,0)
    send_bit(1); send_bit(0); send_bit(1);
    check("t4_pre_out", q_out, 4'b0011);
    q_ready = 1'b1;
    send_bit(0);
    q_ready = 1'b0;
    check("t4_q_out",   q_out,   4'b0101);
    check("t4_q_valid", q_valid, 1);
    check("t4_overrun", overrun, 0);

    // 5a: reset mid-word
    send_bit(1); send_bit(0);
    check("t5_cnt2", bit_cnt, 2);
    rst = 1'b0; step(); rst = 1'b1;
    check("t5_rst_out",   q_out,   0);
    check("t5_rst_valid", q_valid, 0);
    check("t5_rst_cnt",   bit_cnt, 0);
    check("t5_rst_busy",  busy,    0);
    check("t5_rst_ovr",   overrun, 0);
    send_bit(1); send_bit(1); send_bit(1); send_bit(1);
    check("t5_q_out",   q_out,   4'b1111);
    check("t5_q_valid", q_valid, 1);

    // 5b: clear mid-word
    send_bit(0); send_bit(1);
    check("t5c_cnt2", bit_cnt, 2);
    clear = 1'b1; step(); clear = 1'b0;
    check("t5c_out",   q_out,   4'b1111);
    check("t5c_valid", q_valid, 1);
    check("t5c_cnt",   bit_cnt, 0);
    check("t5c_busy",  busy,    0);

    // 6: clear collides with the completing bit
    q_ready = 1'b1; step(); q_ready = 1'b0;
    check("t6_consumed", q_valid, 0);
    send_bit(1); send_bit(1); send_bit(1);
    check("t6_cnt3", bit_cnt, 3);
    clear = 1'b1;
    send_bit(1);
    clear = 1'b0;
    check("t6_cnt",   bit_cnt, 0);
    check("t6_valid", q_valid, 0);
    check("t6_out",   q_out,   4'b1111);

    // A fresh word after the collision starts cleanly (0110 LSB-first: 0,1,1,0)
    send_bit(0); send_bit(1); send_bit(1); send_bit(0);
    check("t6_fresh_out",   q_out,   4'b0110);
    check("t6_fresh_valid", q_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
